// File: rtl/cuckoo_pkg.sv
// Shared types and constants for the cuckoo clock: strike sequencer states,
// time-of-day digit limits and the 24h -> 12h strike-count conversion.
package cuckoo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } strike_state_t;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned NOON    = 12;

  // Midnight and noon both strike twelve times.
  function automatic logic [3:0] to_12h(input logic [4:0] hr);
    logic [3:0] n;
    if (hr == 5'd0) begin
      n = 4'(NOON);
    end else if (hr > 5'(NOON)) begin
      n = 4'(hr - 5'(NOON));
    end else begin
      n = hr[3:0];
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter 00..LIMIT with enable and synchronous clear.
// carry flags the enabled cycle on which the counter wraps back to 00.
module bcd_mod60_counter
  import cuckoo_pkg::*;
#(
  parameter int unsigned LIMIT = SEC_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  localparam logic [2:0] TENS_MAX  = 3'(LIMIT / 10);
  localparam logic [3:0] UNITS_MAX = 4'(LIMIT % 10);

  logic at_max;

  assign at_max = (tens == TENS_MAX) && (units == UNITS_MAX);
  assign carry  = en && at_max && !clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens  <= 3'd0;
      units <= 4'd0;
    end else if (clr) begin
      tens  <= 3'd0;
      units <= 4'd0;
    end else if (en) begin
      if (at_max) begin
        tens  <= 3'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 3'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/cuckoo_timekeeper.sv
// 24-hour BCD time of day with manual setting, plus an hourly strike
// sequencer that pulses cuckoo once per hour in 12-hour count.
module cuckoo_timekeeper
  import cuckoo_pkg::*;
#(
  parameter int unsigned STRIKE_ON  = 1,
  parameter int unsigned STRIKE_OFF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [1:0] hr_t,
  output logic [3:0] hr_u,
  output logic       cuckoo,
  output logic       strike_busy
);

  localparam logic [3:0] ON_LAST  = 4'(STRIKE_ON - 1);
  localparam logic [3:0] OFF_LAST = 4'(STRIKE_OFF - 1);

  logic run_tick, set_min, set_hr;
  logic sec_carry, min_carry, min_en;
  logic hour_event, hr_inc;

  assign run_tick = tick_1hz && !set_en;
  assign set_min  = set_en && inc_min;
  assign set_hr   = set_en && inc_hr;

  bcd_mod60_counter #(.LIMIT(SEC_MAX)) u_sec (
    .clk   (clk),
    .reset (reset),
    .en    (run_tick),
    .clr   (set_min),
    .tens  (sec_t),
    .units (sec_u),
    .carry (sec_carry)
  );

  assign min_en = sec_carry || set_min;

  bcd_mod60_counter #(.LIMIT(MIN_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .en    (min_en),
    .clr   (1'b0),
    .tens  (min_t),
    .units (min_u),
    .carry (min_carry)
  );

  // A minute wrap only reaches the hours when it came from a run-mode tick.
  assign hour_event = min_carry && !set_en;
  assign hr_inc     = hour_event || set_hr;

  logic [4:0] hr_bin, hr_bin_next;
  logic       hr_at_max;
  logic [1:0] hr_t_next;
  logic [3:0] hr_u_next;
  logic [3:0] strike_n;

  assign hr_bin      = 5'(hr_t) * 5'd10 + 5'(hr_u);
  assign hr_at_max   = (hr_bin == 5'(HR_MAX));
  assign hr_bin_next = hr_at_max ? 5'd0 : hr_bin + 5'd1;
  assign strike_n    = to_12h(hr_bin_next);

  always_comb begin
    hr_t_next = hr_t;
    hr_u_next = hr_u + 4'd1;
    if (hr_at_max) begin
      hr_t_next = 2'd0;
      hr_u_next = 4'd0;
    end else if (hr_u == 4'd9) begin
      hr_t_next = hr_t + 2'd1;
      hr_u_next = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hr_t <= 2'd0;
      hr_u <= 4'd0;
    end else if (hr_inc) begin
      hr_t <= hr_t_next;
      hr_u <= hr_u_next;
    end
  end

  // Strike sequencer
  strike_state_t state, state_next;
  logic [3:0]    left, left_next;
  logic [3:0]    phase, phase_next;
  logic          set_en_q, set_rise;

  assign set_rise = set_en && !set_en_q;

  always_comb begin
    state_next = state;
    left_next  = left;
    phase_next = phase;
    if (set_rise) begin
      state_next = ST_IDLE;
      left_next  = 4'd0;
      phase_next = 4'd0;
    end else if (hour_event) begin
      state_next = ST_ON;
      left_next  = strike_n - 4'd1;
      phase_next = 4'd0;
    end else if (tick_1hz) begin
      case (state)
        ST_ON: begin
          if (phase == ON_LAST) begin
            phase_next = 4'd0;
            state_next = (left == 4'd0) ? ST_IDLE : ST_OFF;
          end else begin
            phase_next = phase + 4'd1;
          end
        end
        ST_OFF: begin
          if (phase == OFF_LAST) begin
            phase_next = 4'd0;
            state_next = ST_ON;
            left_next  = left - 4'd1;
          end else begin
            phase_next = phase + 4'd1;
          end
        end
        default: begin
          phase_next = phase;
        end
      endcase
    end
  end

  // Outputs come from their own flops so they are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      left        <= 4'd0;
      phase       <= 4'd0;
      set_en_q    <= 1'b0;
      cuckoo      <= 1'b0;
      strike_busy <= 1'b0;
    end else begin
      state       <= state_next;
      left        <= left_next;
      phase       <= phase_next;
      set_en_q    <= set_en;
      cuckoo      <= (state_next == ST_ON);
      strike_busy <= (state_next != ST_IDLE);
    end
  end

endmodule
